// File: rtl/core_rf_wb_sched.sv
// core_rf_wb_sched
//   Shares the single register-file write port between in-order pipeline
//   writeback and a long-latency return source. Long-latency results wait
//   in a 2-entry FIFO and drain in write slots the pipeline leaves idle.
//   A pending scoreboard lets the issue stage stall on RAW/WAW hazards.
//
// Ports
//   g_clk, g_resetn          clock, asynchronous active-low reset
//   p_wen/p_addr/p_wdata     pipeline writeback (always accepted)
//   l_valid/l_ready/l_addr/l_wdata  long-latency return handshake
//   issue_valid/issue_rd     long-latency issue; issue_ready gates it
//   chk_rs1/chk_rs2/chk_rd   decode operands; hazard requests a stall
//   wb_stall                 registered request to hold pipeline writeback
//   rd_wen/rd_addr/rd_wdata  register-file write port
//   pending                  scoreboard, bit 0 always 0
module core_rf_wb_sched #(
    parameter int unsigned XL         = 63,
    parameter int unsigned RA         = 4,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                   g_clk,
    input  logic                   g_resetn,
    input  logic                   p_wen,
    input  logic [RA:0]            p_addr,
    input  logic [XL:0]            p_wdata,
    input  logic                   l_valid,
    output logic                   l_ready,
    input  logic [RA:0]            l_addr,
    input  logic [XL:0]            l_wdata,
    input  logic                   issue_valid,
    input  logic [RA:0]            issue_rd,
    output logic                   issue_ready,
    input  logic [RA:0]            chk_rs1,
    input  logic [RA:0]            chk_rs2,
    input  logic [RA:0]            chk_rd,
    output logic                   hazard,
    output logic                   wb_stall,
    output logic                   rd_wen,
    output logic [RA:0]            rd_addr,
    output logic [XL:0]            rd_wdata,
    output logic [(2**(RA+1))-1:0] pending
);

    localparam int unsigned NREG = 2 ** (RA + 1);
    localparam int unsigned SCW  = $clog2(STARVE_LIM + 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIM - 1);

    logic [RA:0]     fifo_addr [2];
    logic [XL:0]     fifo_data [2];
    logic [1:0]      count;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [SCW-1:0]  starve_cnt;
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pend_set;
    logic [NREG-1:0] pend_clr;

    logic            push;
    logic            drain;
    logic            blocked;
    logic [RA:0]     head_addr;
    logic [XL:0]     head_data;
    logic            busy_rs1;
    logic            busy_rs2;
    logic            busy_rd;

    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // l_ready depends on count only, never on a same-cycle pop.
    assign l_ready = (count != 2'd2);
    assign push    = l_valid && l_ready;
    assign drain   = !p_wen && (count != 2'd0);
    assign blocked = p_wen && (count != 2'd0);

    always_comb begin
        rd_wen   = 1'b0;
        rd_addr  = head_addr;
        rd_wdata = head_data;
        if (p_wen) begin
            rd_wen   = 1'b1;
            rd_addr  = p_addr;
            rd_wdata = p_wdata;
        end else if (drain) begin
            // x0 results are popped but never written.
            rd_wen = (head_addr != '0);
        end
    end

    assign issue_ready = !pending_q[issue_rd];
    assign pending     = pending_q;

    // The draining register is forwarded by the register file, so it is
    // not considered busy during its own drain cycle.
    assign busy_rs1 = pending_q[chk_rs1] && !(drain && head_addr == chk_rs1);
    assign busy_rs2 = pending_q[chk_rs2] && !(drain && head_addr == chk_rs2);
    assign busy_rd  = pending_q[chk_rd]  && !(drain && head_addr == chk_rd);
    assign hazard   = busy_rs1 | busy_rs2 | busy_rd;

    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (issue_valid && issue_ready && issue_rd != '0) begin
            pend_set[issue_rd] = 1'b1;
        end
        if (drain && head_addr != '0) begin
            pend_clr[head_addr] = 1'b1;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            count        <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_addr[0] <= '0;
            fifo_addr[1] <= '0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
        end else begin
            if (push) begin
                fifo_addr[wr_ptr] <= l_addr;
                fifo_data[wr_ptr] <= l_wdata;
                wr_ptr            <= ~wr_ptr;
            end
            if (drain) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, drain})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Counter saturates at the limit; wb_stall stays set until the head pops.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else if (drain) begin
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else if (blocked) begin
            if (starve_cnt == STARVE_MAX) begin
                wb_stall <= 1'b1;
            end else begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q | pend_set) & ~pend_clr;
        end
    end

    a_drain_pending: assert property (@(posedge g_clk) disable iff (!g_resetn)
        (drain && head_addr != '0) |-> pending_q[head_addr]);

    a_no_waw: assert property (@(posedge g_clk) disable iff (!g_resetn)
        (p_wen && p_addr != '0) |-> !pending_q[p_addr]);

    a_stall_honoured: assert property (@(posedge g_clk) disable iff (!g_resetn)
        wb_stall |-> !p_wen);

endmodule

// File: tb/tb_core_rf_wb_sched.sv
module tb_core_rf_wb_sched;

    logic        g_clk;
    logic        g_resetn;
    logic        p_wen;
    logic [4:0]  p_addr;
    logic [63:0] p_wdata;
    logic        l_valid;
    logic        l_ready;
    logic [4:0]  l_addr;
    logic [63:0] l_wdata;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        hazard;
    logic        wb_stall;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [63:0] rd_wdata;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;

    core_rf_wb_sched #(.XL(63), .RA(4), .STARVE_LIM(4)) dut (
        .g_clk       (g_clk),
        .g_resetn    (g_resetn),
        .p_wen       (p_wen),
        .p_addr      (p_addr),
        .p_wdata     (p_wdata),
        .l_valid     (l_valid),
        .l_ready     (l_ready),
        .l_addr      (l_addr),
        .l_wdata     (l_wdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .chk_rd      (chk_rd),
        .hazard      (hazard),
        .wb_stall    (wb_stall),
        .rd_wen      (rd_wen),
        .rd_addr     (rd_addr),
        .rd_wdata    (rd_wdata),
        .pending     (pending)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    typedef struct {
        logic        pw;
        logic [4:0]  pa;
        logic [63:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [63:0] ld;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rdc;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [63:0] e_data;
        logic        e_lrdy;
        logic        e_irdy;
        logic        e_haz;
        logic        e_stall;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic pw, input logic [4:0] pa, input logic [63:0] pd,
        input logic lv, input logic [4:0] la, input logic [63:0] ld,
        input logic iv, input logic [4:0] ir,
        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdc,
        input logic e_wen, input logic [4:0] e_addr, input logic [63:0] e_data,
        input logic e_lrdy, input logic e_irdy, input logic e_haz, input logic e_stall,
        input logic [31:0] e_pend);
        vec_t v;
        v.pw = pw; v.pa = pa; v.pd = pd;
        v.lv = lv; v.la = la; v.ld = ld;
        v.iv = iv; v.ir = ir;
        v.r1 = r1; v.r2 = r2; v.rdc = rdc;
        v.e_wen = e_wen; v.e_addr = e_addr; v.e_data = e_data;
        v.e_lrdy = e_lrdy; v.e_irdy = e_irdy; v.e_haz = e_haz; v.e_stall = e_stall;
        v.e_pend = e_pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        p_wen = v.pw; p_addr = v.pa; p_wdata = v.pd;
        l_valid = v.lv; l_addr = v.la; l_wdata = v.ld;
        issue_valid = v.iv; issue_rd = v.ir;
        chk_rs1 = v.r1; chk_rs2 = v.r2; chk_rd = v.rdc;
    endtask

    task automatic idle_inputs();
        p_wen = 0; p_addr = 0; p_wdata = 0;
        l_valid = 0; l_addr = 0; l_wdata = 0;
        issue_valid = 0; issue_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
    endtask

    // Called at posedge+1; checks on the falling edge, returns at next posedge+1.
    task automatic apply(input int idx, input vec_t v);
        string tag;
        drive(v);
        @(negedge g_clk);
        tag = $sformatf("v%0d", idx);
        chk({tag, ".rd_wen"}, 64'(rd_wen), 64'(v.e_wen));
        if (v.e_wen) begin
            chk({tag, ".rd_addr"}, 64'(rd_addr), 64'(v.e_addr));
            chk({tag, ".rd_wdata"}, rd_wdata, v.e_data);
        end
        chk({tag, ".l_ready"}, 64'(l_ready), 64'(v.e_lrdy));
        chk({tag, ".issue_ready"}, 64'(issue_ready), 64'(v.e_irdy));
        chk({tag, ".hazard"}, 64'(hazard), 64'(v.e_haz));
        chk({tag, ".wb_stall"}, 64'(wb_stall), 64'(v.e_stall));
        chk({tag, ".pending"}, 64'(pending), 64'(v.e_pend));
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        //                 pw pa pd        lv la ld         iv ir  r1 r2 rd  ew ea ed          lr ir hz st pend
        // issue x5, return, drain
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         1, 5,  5, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,        1, 5, 64'hDEAD,  0, 0,  5, 0, 0,  0, 0, 0,          1, 1, 1, 0, 32'h20));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         0, 0,  5, 0, 0,  1, 5, 64'hDEAD,   1, 1, 0, 0, 32'h20));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         0, 0,  5, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h0));
        // scoreboard block on x9
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         1, 9,  0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         1, 9,  0, 0, 9,  0, 0, 0,          1, 0, 1, 0, 32'h200));
        vecs.push_back(mk(0, 0, 0,        1, 9, 64'h99,    1, 9,  0, 9, 0,  0, 0, 0,          1, 0, 1, 0, 32'h200));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         1, 9,  0, 9, 0,  1, 9, 64'h99,     1, 0, 0, 0, 32'h200));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         1, 9,  0, 9, 0,  0, 0, 0,          1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,        1, 9, 64'h1234,  0, 0,  0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h200));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         0, 0,  0, 0, 0,  1, 9, 64'h1234,   1, 1, 0, 0, 32'h200));
        // x0 issue and x0 return
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         1, 0,  0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,        1, 0, 64'h55,    0, 0,  0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         0, 0,  0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         1, 6,  0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,        1, 6, 64'h66,    0, 0,  6, 0, 0,  0, 0, 0,          1, 1, 1, 0, 32'h40));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         0, 0,  0, 0, 0,  1, 6, 64'h66,     1, 1, 0, 0, 32'h40));
        // pipeline writes, including x0 pass-through
        vecs.push_back(mk(1, 0, 64'hAB,   0, 0, 0,         0, 0,  0, 0, 0,  1, 0, 64'hAB,     1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 3, 64'h33,   0, 0, 0,         0, 0,  0, 0, 0,  1, 3, 64'h33,     1, 1, 0, 0, 32'h0));
        // contention and starvation guard
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         1, 7,  0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         1, 8,  0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h80));
        vecs.push_back(mk(1, 3, 64'h300,  1, 7, 64'h77,    0, 0,  0, 0, 0,  1, 3, 64'h300,    1, 1, 0, 0, 32'h180));
        vecs.push_back(mk(1, 3, 64'h301,  1, 8, 64'h88,    0, 0,  0, 0, 0,  1, 3, 64'h301,    1, 1, 0, 0, 32'h180));
        vecs.push_back(mk(1, 3, 64'h302,  0, 0, 0,         0, 0,  0, 0, 0,  1, 3, 64'h302,    0, 1, 0, 0, 32'h180));
        vecs.push_back(mk(1, 3, 64'h303,  0, 0, 0,         0, 0,  0, 0, 0,  1, 3, 64'h303,    0, 1, 0, 0, 32'h180));
        vecs.push_back(mk(1, 3, 64'h304,  0, 0, 0,         0, 0,  0, 0, 0,  1, 3, 64'h304,    0, 1, 0, 0, 32'h180));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         0, 0,  7, 0, 0,  1, 7, 64'h77,     0, 1, 0, 1, 32'h180));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         0, 0,  8, 0, 0,  1, 8, 64'h88,     1, 1, 0, 0, 32'h100));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         0, 0,  0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h0));
        // push while draining at count 1
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         1, 10, 0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         1, 11, 0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h400));
        vecs.push_back(mk(0, 0, 0,        1, 10, 64'hA0,   0, 0,  0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'hC00));
        vecs.push_back(mk(0, 0, 0,        1, 11, 64'hB0,   0, 0,  0, 0, 0,  1, 10, 64'hA0,    1, 1, 0, 0, 32'hC00));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         0, 0,  0, 0, 0,  1, 11, 64'hB0,    1, 1, 0, 0, 32'h800));
        vecs.push_back(mk(0, 0, 0,        0, 0, 0,         0, 0,  0, 0, 0,  0, 0, 0,          1, 1, 0, 0, 32'h0));

        // reset state
        idle_inputs();
        g_resetn = 1'b0;
        #12;
        chk("reset.pending", 64'(pending), 64'h0);
        chk("reset.l_ready", 64'(l_ready), 64'h1);
        chk("reset.rd_wen", 64'(rd_wen), 64'h0);
        chk("reset.wb_stall", 64'(wb_stall), 64'h0);
        chk("reset.issue_ready", 64'(issue_ready), 64'h1);
        chk("reset.hazard", 64'(hazard), 64'h0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // reset mid-operation with two entries queued behind pipeline writes
        idle_inputs(); issue_valid = 1; issue_rd = 12;
        @(posedge g_clk); #1;
        issue_rd = 13;
        @(posedge g_clk); #1;
        idle_inputs(); p_wen = 1; p_addr = 3; p_wdata = 64'h5; l_valid = 1; l_addr = 12; l_wdata = 64'hC0;
        @(posedge g_clk); #1;
        l_addr = 13; l_wdata = 64'hD0;
        @(posedge g_clk); #1;
        idle_inputs(); p_wen = 1; p_addr = 3; p_wdata = 64'h6; issue_rd = 12;
        #2;
        chk("midrst.full_before", 64'(l_ready), 64'h0);
        chk("midrst.pend_before", 64'(pending), 64'h3000);
        g_resetn = 1'b0;
        p_wen = 0;
        #1;
        chk("midrst.pending", 64'(pending), 64'h0);
        chk("midrst.l_ready", 64'(l_ready), 64'h1);
        chk("midrst.rd_wen", 64'(rd_wen), 64'h0);
        chk("midrst.issue_ready", 64'(issue_ready), 64'h1);
        @(negedge g_clk);
        g_resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge g_clk);
            chk($sformatf("postrst%0d.rd_wen", c), 64'(rd_wen), 64'h0);
            chk($sformatf("postrst%0d.pending", c), 64'(pending), 64'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
